// File: rtl/wire_op_engine.sv
// Purpose: host-polled operand engine (add/sub/acc/clr single-cycle, shift-add multiply) behind FrontPanel wires.
// Latency: busy is set at the start edge; single-cycle ops complete one edge later, multiply WIDTH edges later.
// Backpressure: none; a start toggle seen while busy is dropped and flagged as overrun in the status word.
module wire_op_engine #(
    parameter int WIDTH = 32
) (
    input  logic             okClk,
    input  logic             okRst_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [31:0]      cmd,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [31:0]      status
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_ACC = 3'd3;
    localparam logic [2:0] OP_CLR = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 cmd_t_q, cmd_t_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2:0]           opc_q, opc_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 tog_q, tog_d;
    logic [CW-1:0]        mul_cnt_q, mul_cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic                 start;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   add_sum;
    logic [WIDTH-1:0]     sub_diff;
    logic [2*WIDTH-1:0]   mul_partial;
    logic                 unused_cmd_bits;

    // Only the opcode and the toggle bit carry meaning.
    assign unused_cmd_bits = ^cmd[30:3];

    // A command is launched by inverting cmd[31] relative to the previous cycle.
    assign start = cmd[31] ^ cmd_t_q;

    // Datapath terms shared by the next-state logic.
    assign add_sum     = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
    assign sub_diff    = a_q - b_q;
    assign acc_sum     = acc_q + {{WIDTH{1'b0}}, a_q};
    assign mul_partial = prod_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});

    // Next-state and output-register logic for the IDLE/EXEC/MUL controller.
    always_comb begin
        state_d   = state_q;
        cmd_t_d   = cmd[31];
        a_d       = a_q;
        b_d       = b_q;
        opc_d     = opc_q;
        acc_d     = acc_q;
        res_d     = res_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        ovr_d     = ovr_q;
        cnt_d     = cnt_q;
        tog_d     = tog_q;
        mul_cnt_d = mul_cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d    = op_a;
                    b_d    = op_b;
                    opc_d  = cmd[2:0];
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    ovr_d  = 1'b0;
                    busy_d = 1'b1;
                    tog_d  = cmd[31];
                    if (cmd[2:0] == OP_MUL) begin
                        state_d   = S_MUL;
                        mul_cnt_d = '0;
                        mcand_d   = {{WIDTH{1'b0}}, op_a};
                        mplier_d  = op_b;
                        prod_d    = '0;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                // A toggle landing on the completion edge is still a busy-time start.
                if (start) begin
                    ovr_d = 1'b1;
                end
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                case (opc_q)
                    OP_ADD: res_d = add_sum;
                    OP_SUB: res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q), sub_diff};
                    OP_ACC: begin
                        acc_d = acc_sum;
                        res_d = acc_sum;
                    end
                    OP_CLR: begin
                        acc_d = '0;
                        res_d = '0;
                    end
                    default: begin
                        err_d = 1'b1;
                        cnt_d = cnt_q;
                    end
                endcase
            end

            S_MUL: begin
                if (start) begin
                    ovr_d = 1'b1;
                end
                prod_d    = mul_partial;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                mul_cnt_d = mul_cnt_q + 1'b1;
                if (mul_cnt_q == CW'(WIDTH - 1)) begin
                    res_d   = mul_partial;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge okClk or negedge okRst_n) begin
        if (!okRst_n) begin
            state_q   <= S_IDLE;
            cmd_t_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            opc_q     <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
            tog_q     <= 1'b0;
            mul_cnt_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_t_q   <= cmd_t_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opc_q     <= opc_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            mul_cnt_q <= mul_cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
        end
    end

    assign result_lo = res_q[WIDTH-1:0];
    assign result_hi = res_q[2*WIDTH-1:WIDTH];
    assign status    = {tog_q, 15'b0, cnt_q, 4'b0, ovr_q, err_q, done_q, busy_q};

endmodule

// File: tb/tb_wire_op_engine.sv
// Purpose: directed plus randomized checks of wire_op_engine against an arithmetic reference model.
// Latency: each operation is timed from its accepted start edge to the edge where busy drops.
// Backpressure: exercises toggles while busy, including on the completion edge, and reset mid-multiply.
module tb_wire_op_engine;

    logic        okClk;
    logic        okRst_n;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] cmd;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [31:0] status;

    int checks;
    int errors;

    // Reference model state
    logic [63:0] m_acc;
    logic [63:0] m_res;
    logic [7:0]  m_cnt;
    logic        m_tog;
    logic        cmd_bit;

    wire_op_engine #(.WIDTH(32)) dut (
        .okClk     (okClk),
        .okRst_n   (okRst_n),
        .op_a      (op_a),
        .op_b      (op_b),
        .cmd       (cmd),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .status    (status)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic ovr, input logic err);
        return {m_tog, 15'b0, m_cnt, 4'b0, ovr, err, 1'b1, 1'b0};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Apply one accepted operation to the model using plain arithmetic.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        case (op)
            3'd0: m_res = {32'h0, a} + {32'h0, b};
            3'd1: begin
                d     = a - b;
                m_res = {31'h0, (a < b), d};
            end
            3'd2: m_res = {32'h0, a} * {32'h0, b};
            3'd3: begin
                m_acc = m_acc + {32'h0, a};
                m_res = m_acc;
            end
            3'd4: begin
                m_acc = 64'h0;
                m_res = 64'h0;
            end
            default: ;
        endcase
        if (op <= 3'd4) m_cnt = m_cnt + 8'd1;
    endtask

    // Launch one command, optionally re-toggle ovr_at cycles after acceptance, then check completion.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ovr_at);
        int   cyc;
        logic ovr;
        op_a    = a;
        op_b    = b;
        cmd_bit = ~cmd_bit;
        cmd     = {cmd_bit, 28'h0, op};
        @(posedge okClk); #1;
        check({tag, "/busy_at_E"}, 64'(status[0]), 64'd1);
        m_tog = cmd_bit;
        model_apply(op, a, b);
        // Inputs changing after acceptance must not disturb the operation.
        op_a     = $urandom;
        op_b     = $urandom;
        cmd[2:0] = 3'($urandom_range(0, 7));
        cyc = 0;
        ovr = 1'b0;
        while (status[0] === 1'b1 && cyc < 100) begin
            if (cyc == ovr_at) begin
                cmd_bit = ~cmd_bit;
                cmd[31] = cmd_bit;
                ovr     = 1'b1;
            end
            @(posedge okClk); #1;
            cyc++;
        end
        check({tag, "/busy_cycles"}, 64'(cyc), (op == 3'd2) ? 64'd32 : 64'd1);
        check({tag, "/result"}, {result_hi, result_lo}, m_res);
        check({tag, "/status"}, 64'(status), 64'(exp_status(ovr, op > 3'd4)));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_acc   = 64'h0;
        m_res   = 64'h0;
        m_cnt   = 8'h0;
        m_tog   = 1'b0;
        cmd_bit = 1'b0;
        okRst_n = 1'b0;
        op_a    = 32'h0;
        op_b    = 32'h0;
        cmd     = 32'h0;

        // Reset state
        #12;
        check("reset/result", {result_hi, result_lo}, 64'h0);
        check("reset/status", 64'(status), 64'h0);
        @(negedge okClk);
        okRst_n = 1'b1;
        repeat (2) @(posedge okClk);
        #1;
        check("idle/status", 64'(status), 64'h0);

        // ADD with carry out
        run_op("add_carry", 3'd0, 32'hFFFF_FFFF, 32'h1, -1);
        check("add_carry/const", {result_hi, result_lo}, 64'h1_0000_0000);
        check("add_carry/op_count", 64'(status[15:8]), 64'd1);

        // SUB with borrow
        run_op("sub_borrow", 3'd1, 32'd5, 32'd7, -1);
        check("sub_borrow/const", {result_hi, result_lo}, 64'h1_FFFF_FFFE);

        // Full-scale multiply
        run_op("mul_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("mul_max/const", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);

        // Multiply with a toggle 10 cycles in: dropped, overrun flagged
        run_op("mul_overrun", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9);
        check("mul_overrun/ovr", 64'(status[3]), 64'd1);
        check("mul_overrun/op_count", 64'(status[15:8]), 64'd4);

        // Next accepted command clears overrun
        run_op("after_overrun", 3'd0, 32'd2, 32'd3, -1);

        // Toggle landing on the EXEC completion edge
        run_op("exec_edge_ovr", 3'd1, 32'd9, 32'd4, 0);

        // Accumulator sequence, illegal opcode, accumulator survives ADD
        run_op("clr", 3'd4, 32'h1234, 32'h0, -1);
        for (int i = 0; i < 3; i++) run_op("acc", 3'd3, 32'h8000_0000, 32'h0, -1);
        check("acc3/const", {result_hi, result_lo}, 64'h1_8000_0000);
        run_op("illegal6", 3'd6, 32'h5, 32'h6, -1);
        check("illegal6/result_kept", {result_hi, result_lo}, 64'h1_8000_0000);
        run_op("add_1_1", 3'd0, 32'd1, 32'd1, -1);
        check("add_1_1/lo", 64'(result_lo), 64'd2);
        run_op("acc_zero", 3'd3, 32'h0, 32'h0, -1);
        check("acc_zero/const", {result_hi, result_lo}, 64'h1_8000_0000);

        // Randomized operations with occasional idle gaps and busy-time toggles
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            int         oa;
            op = 3'($urandom_range(0, 7));
            oa = (op == 3'd2) ? $urandom_range(0, 45) : $urandom_range(0, 3) - 1;
            run_op("rand", op, pick(), pick(), oa);
            repeat ($urandom_range(0, 3)) @(posedge okClk);
            #1;
        end

        // Reset in the middle of a multiply, with cmd[31] held high through reset
        op_a    = 32'hDEAD_BEEF;
        op_b    = 32'h1234_5678;
        cmd_bit = ~cmd_bit;
        cmd     = {cmd_bit, 28'h0, 3'd2};
        @(posedge okClk); #1;
        repeat (6) @(posedge okClk);
        #1;
        check("mid_mul/busy", 64'(status[0]), 64'd1);
        okRst_n = 1'b0;
        cmd     = {1'b1, 28'h0, 3'd0};
        op_a    = 32'd3;
        op_b    = 32'd4;
        #1;
        check("mid_mul_reset/result", {result_hi, result_lo}, 64'h0);
        check("mid_mul_reset/status", 64'(status), 64'h0);
        repeat (2) @(posedge okClk);
        #1;
        check("reset_hold/status", 64'(status), 64'h0);
        m_acc   = 64'h0;
        m_res   = 64'h0;
        m_cnt   = 8'h0;
        cmd_bit = 1'b1;
        @(negedge okClk);
        okRst_n = 1'b1;
        @(posedge okClk); #1;
        check("release/busy", 64'(status[0]), 64'd1);
        m_tog = 1'b1;
        model_apply(3'd0, 32'd3, 32'd4);
        @(posedge okClk); #1;
        check("release/lo", 64'(result_lo), 64'd7);
        check("release/status", 64'(status), 64'(exp_status(1'b0, 1'b0)));

        // Accumulator restarted from zero after reset
        run_op("post_reset_acc", 3'd3, 32'h55, 32'h0, -1);
        check("post_reset_acc/const", {result_hi, result_lo}, 64'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
